// File: rtl/sys_defs.sv
// Shared system definitions: bus commands, memory tag width and instruction cache types.
package sys_defs;

  localparam int XLEN      = 32;
  localparam int MEM_TAG_W = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  localparam int ICACHE_LINES = 32;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_LINES);
  localparam int ICACHE_TAG_W = XLEN - 3 - ICACHE_IDX_W;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [63:0]             data;
  } ICACHE_LINE;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_WAIT = 1'b1
  } ICACHE_STATE;

endpackage

// File: rtl/icache_mem.sv
// Instruction cache line array: one combinational read port, one synchronous
// write port; reset clears only the valid bits.
module icache_mem
  import sys_defs::*;
#(
  parameter int NUM_LINES = ICACHE_LINES,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output ICACHE_LINE       rd_line,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  ICACHE_LINE       wr_line
);

  ICACHE_LINE lines_q [NUM_LINES];
  ICACHE_LINE lines_d [NUM_LINES];

  function automatic ICACHE_LINE clear_valid(input ICACHE_LINE line);
    ICACHE_LINE cleared;
    cleared       = line;
    cleared.valid = 1'b0;
    return cleared;
  endfunction

  always_comb begin
    lines_d = lines_q;
    if (wr_en) begin
      lines_d[wr_idx] = wr_line;
    end
  end

  // Tag and data contents survive reset; only validity is forgotten.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        lines_q[i] <= clear_valid(lines_q[i]);
      end
    end else begin
      lines_q <= lines_d;
    end
  end

  assign rd_line = lines_q[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped blocking instruction cache: combinational hit lookup for fetch,
// single outstanding tagged BUS_LOAD on a miss, yielding the bus to the data cache.
module icache_ctrl
  import sys_defs::*;
#(
  parameter int NUM_LINES = ICACHE_LINES,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = 32 - 3 - IDX_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          proc2Icache_addr,
  input  logic [1:0]           Dcache2memcommond,
  input  logic [MEM_TAG_W-1:0] Imem2proc_response,
  input  logic [63:0]          Imem2proc_data,
  input  logic [MEM_TAG_W-1:0] Imem2proc_tag,
  output logic [1:0]           proc2Imem_command,
  output logic [31:0]          proc2Imem_addr,
  output logic [63:0]          Icache_data_out,
  output logic                 Icache_valid_out
);

  ICACHE_STATE          state_q, state_d;
  logic [MEM_TAG_W-1:0] pend_tag_q, pend_tag_d;
  logic [31:3]          pend_addr_q, pend_addr_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] addr_tag;
  logic [31:3]      blk_addr;
  ICACHE_LINE       rd_line;
  ICACHE_LINE       wr_line;
  logic             wr_en;
  logic             hit;
  logic             miss_req;
  logic             fill;
  logic             unused_offset;

  assign idx           = proc2Icache_addr[IDX_W+2:3];
  assign addr_tag      = proc2Icache_addr[31:IDX_W+3];
  assign blk_addr      = proc2Icache_addr[31:3];
  assign unused_offset = ^proc2Icache_addr[2:0];

  assign hit      = reset && rd_line.valid && (rd_line.tag == addr_tag);
  assign miss_req = reset && (state_q == IC_IDLE) && !hit && (Dcache2memcommond == BUS_NONE);
  // Tag 0 means "no data", so an empty pend_tag can never match a return.
  assign fill     = reset && (state_q == IC_WAIT) && (pend_tag_q != '0) &&
                    (Imem2proc_tag == pend_tag_q);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IC_IDLE;
      pend_tag_q  <= '0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_tag_q  <= pend_tag_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_tag_d  = pend_tag_q;
    pend_addr_d = pend_addr_q;
    unique case (state_q)
      IC_IDLE: begin
        if (miss_req && (Imem2proc_response != '0)) begin
          state_d     = IC_WAIT;
          pend_tag_d  = Imem2proc_response;
          pend_addr_d = blk_addr;
        end
      end
      IC_WAIT: begin
        if (fill) begin
          state_d    = IC_IDLE;
          pend_tag_d = '0;
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

  always_comb begin
    proc2Imem_command = BUS_NONE;
    proc2Imem_addr    = '0;
    if (miss_req) begin
      proc2Imem_command = BUS_LOAD;
      proc2Imem_addr    = {blk_addr, 3'b000};
    end
    wr_en         = fill;
    wr_line.valid = 1'b1;
    wr_line.tag   = pend_addr_q[31:IDX_W+3];
    wr_line.data  = Imem2proc_data;
  end

  icache_mem #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .rd_idx  (idx),
    .rd_line (rd_line),
    .wr_en   (wr_en),
    .wr_idx  (pend_addr_q[IDX_W+2:3]),
    .wr_line (wr_line)
  );

  assign Icache_data_out  = rd_line.data;
  assign Icache_valid_out = hit;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed, table-driven bench for icache_ctrl: one table row per clock cycle,
// plus a hand-written sequence for reset during an outstanding miss.
module tb_icache_ctrl;

  localparam logic [1:0] C_NONE = 2'h0;
  localparam logic [1:0] C_LOAD = 2'h1;

  logic        clock;
  logic        reset;
  logic [31:0] proc2Icache_addr;
  logic [1:0]  Dcache2memcommond;
  logic [3:0]  Imem2proc_response;
  logic [63:0] Imem2proc_data;
  logic [3:0]  Imem2proc_tag;
  logic [1:0]  proc2Imem_command;
  logic [31:0] proc2Imem_addr;
  logic [63:0] Icache_data_out;
  logic        Icache_valid_out;

  int checks = 0;
  int errors = 0;

  icache_ctrl dut (
    .clock              (clock),
    .reset              (reset),
    .proc2Icache_addr   (proc2Icache_addr),
    .Dcache2memcommond  (Dcache2memcommond),
    .Imem2proc_response (Imem2proc_response),
    .Imem2proc_data     (Imem2proc_data),
    .Imem2proc_tag      (Imem2proc_tag),
    .proc2Imem_command  (proc2Imem_command),
    .proc2Imem_addr     (proc2Imem_addr),
    .Icache_data_out    (Icache_data_out),
    .Icache_valid_out   (Icache_valid_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic [31:0] addr;
    logic [1:0]  dcmd;
    logic [3:0]  resp;
    logic [3:0]  mtag;
    logic [63:0] mdata;
    logic [1:0]  e_cmd;
    logic [31:0] e_paddr;
    logic        e_valid;
    logic        chk_data;
    logic [63:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_n, input logic [31:0] addr, input logic [1:0] dcmd,
                              input logic [3:0] resp, input logic [3:0] mtag, input logic [63:0] mdata,
                              input logic [1:0] e_cmd, input logic [31:0] e_paddr, input logic e_valid,
                              input logic chk_data, input logic [63:0] e_data);
    vec_t v;
    v.rst_n = rst_n; v.addr = addr; v.dcmd = dcmd; v.resp = resp; v.mtag = mtag;
    v.mdata = mdata; v.e_cmd = e_cmd; v.e_paddr = e_paddr; v.e_valid = e_valid;
    v.chk_data = chk_data; v.e_data = e_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Drive one cycle's inputs, compare outputs mid-cycle, then cross the edge.
  task automatic apply(input vec_t v, input string tag);
    reset              = v.rst_n;
    proc2Icache_addr   = v.addr;
    Dcache2memcommond  = v.dcmd;
    Imem2proc_response = v.resp;
    Imem2proc_tag      = v.mtag;
    Imem2proc_data     = v.mdata;
    @(negedge clock);
    check({tag, " cmd"},   64'(proc2Imem_command), 64'(v.e_cmd));
    check({tag, " paddr"}, 64'(proc2Imem_addr),    64'(v.e_paddr));
    check({tag, " valid"}, 64'(Icache_valid_out),  64'(v.e_valid));
    if (v.chk_data) check({tag, " data"}, Icache_data_out, v.e_data);
    @(posedge clock);
    #1;
  endtask

  localparam logic [63:0] D104 = 64'hDEADBEEF_00000013;
  localparam logic [63:0] D200 = 64'h11112222_33334444;
  localparam logic [63:0] D040 = 64'hAAAA0000_00000040;
  localparam logic [63:0] D300 = 64'h33330000_00000300;
  localparam logic [63:0] D008 = 64'h00000000_00000808;
  localparam logic [63:0] D108 = 64'h00000000_01080108;
  localparam logic [63:0] JUNK = 64'hBAD0BAD0_BAD0BAD0;

  initial begin
    reset = 1'b0; proc2Icache_addr = '0; Dcache2memcommond = C_NONE;
    Imem2proc_response = '0; Imem2proc_tag = '0; Imem2proc_data = '0;

    // reset, then first miss at 0x0 (rejected)
    vecs.push_back(mk(0, 32'h000, C_NONE, 0, 0, 0,    C_NONE, 32'h0,   0, 0, 0));
    vecs.push_back(mk(0, 32'h000, C_NONE, 0, 0, 0,    C_NONE, 32'h0,   0, 0, 0));
    vecs.push_back(mk(1, 32'h000, C_NONE, 0, 0, 0,    C_LOAD, 32'h0,   0, 0, 0));
    // cold miss 0x104, tag 3, return 4 cycles later
    vecs.push_back(mk(1, 32'h104, C_NONE, 3, 0, 0,    C_LOAD, 32'h100, 0, 0, 0));
    vecs.push_back(mk(1, 32'h104, C_NONE, 0, 0, 0,    C_NONE, 32'h0,   0, 0, 0));
    vecs.push_back(mk(1, 32'h104, C_NONE, 0, 0, 0,    C_NONE, 32'h0,   0, 0, 0));
    vecs.push_back(mk(1, 32'h104, C_NONE, 0, 0, 0,    C_NONE, 32'h0,   0, 0, 0));
    vecs.push_back(mk(1, 32'h104, C_NONE, 0, 3, D104, C_NONE, 32'h0,   0, 0, 0));
    vecs.push_back(mk(1, 32'h104, C_NONE, 0, 0, 0,    C_NONE, 32'h0,   1, 1, D104));
    // miss 0x200 blocked by data cache for 3 cycles
    vecs.push_back(mk(1, 32'h200, C_LOAD, 0, 0, 0,    C_NONE, 32'h0,   0, 0, 0));
    vecs.push_back(mk(1, 32'h200, C_LOAD, 0, 0, 0,    C_NONE, 32'h0,   0, 0, 0));
    vecs.push_back(mk(1, 32'h200, C_LOAD, 0, 0, 0,    C_NONE, 32'h0,   0, 0, 0));
    // two rejections then accepted with tag 5
    vecs.push_back(mk(1, 32'h200, C_NONE, 0, 0, 0,    C_LOAD, 32'h200, 0, 0, 0));
    vecs.push_back(mk(1, 32'h200, C_NONE, 0, 0, 0,    C_LOAD, 32'h200, 0, 0, 0));
    vecs.push_back(mk(1, 32'h200, C_NONE, 5, 0, 0,    C_LOAD, 32'h200, 0, 0, 0));
    // foreign tag 2 ignored; 0x104 still hits while waiting
    vecs.push_back(mk(1, 32'h200, C_NONE, 0, 2, JUNK, C_NONE, 32'h0,   0, 0, 0));
    vecs.push_back(mk(1, 32'h104, C_NONE, 0, 0, 0,    C_NONE, 32'h0,   1, 1, D104));
    vecs.push_back(mk(1, 32'h200, C_NONE, 0, 5, D200, C_NONE, 32'h0,   0, 0, 0));
    vecs.push_back(mk(1, 32'h200, C_NONE, 0, 0, 0,    C_NONE, 32'h0,   1, 1, D200));
    // 0x104 evicted by 0x200 (same index 0): re-requests
    vecs.push_back(mk(1, 32'h104, C_NONE, 0, 0, 0,    C_LOAD, 32'h100, 0, 0, 0));
    // fill 0x40, then redirect during the 0x300 miss
    vecs.push_back(mk(1, 32'h040, C_NONE, 7, 0, 0,    C_LOAD, 32'h040, 0, 0, 0));
    vecs.push_back(mk(1, 32'h040, C_NONE, 0, 7, D040, C_NONE, 32'h0,   0, 0, 0));
    vecs.push_back(mk(1, 32'h300, C_NONE, 1, 0, 0,    C_LOAD, 32'h300, 0, 0, 0));
    vecs.push_back(mk(1, 32'h040, C_NONE, 0, 0, 0,    C_NONE, 32'h0,   1, 1, D040));
    vecs.push_back(mk(1, 32'h040, C_NONE, 0, 1, D300, C_NONE, 32'h0,   1, 1, D040));
    vecs.push_back(mk(1, 32'h300, C_NONE, 0, 0, 0,    C_NONE, 32'h0,   1, 1, D300));
    // conflict on index 1: 0x008 then 0x108
    vecs.push_back(mk(1, 32'h008, C_NONE, 2, 0, 0,    C_LOAD, 32'h008, 0, 0, 0));
    vecs.push_back(mk(1, 32'h008, C_NONE, 0, 2, D008, C_NONE, 32'h0,   0, 0, 0));
    vecs.push_back(mk(1, 32'h00C, C_NONE, 0, 0, 0,    C_NONE, 32'h0,   1, 1, D008));
    vecs.push_back(mk(1, 32'h108, C_NONE, 4, 0, 0,    C_LOAD, 32'h108, 0, 0, 0));
    vecs.push_back(mk(1, 32'h108, C_NONE, 0, 4, D108, C_NONE, 32'h0,   0, 0, 0));
    vecs.push_back(mk(1, 32'h108, C_NONE, 0, 0, 0,    C_NONE, 32'h0,   1, 1, D108));
    vecs.push_back(mk(1, 32'h008, C_NONE, 0, 0, 0,    C_LOAD, 32'h008, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during WAIT abandons the miss; its later return must not fill.
    apply(mk(1, 32'h600, C_NONE, 6, 0, 0,    C_LOAD, 32'h600, 0, 0, 0), "rw_req");
    apply(mk(1, 32'h300, C_NONE, 0, 0, 0,    C_NONE, 32'h0,   1, 1, D300), "rw_wait_hit");
    apply(mk(0, 32'h300, C_NONE, 0, 0, 0,    C_NONE, 32'h0,   0, 0, 0), "rw_in_reset");
    apply(mk(1, 32'h300, C_LOAD, 0, 6, JUNK, C_NONE, 32'h0,   0, 0, 0), "rw_stale_ret");
    apply(mk(1, 32'h600, C_LOAD, 0, 0, 0,    C_NONE, 32'h0,   0, 0, 0), "rw_no_fill");
    apply(mk(1, 32'h600, C_NONE, 0, 0, 0,    C_LOAD, 32'h600, 0, 0, 0), "rw_idle_req");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
